// File: rtl/chroma_pkg.sv
// Shared types and constants for the chroma-key settings sequencer.
//   state_t : sequencer FSM states
//   tgt_t   : which settings register a press adjusts
//   dir_t   : decoded button direction
//   ton_step / color_step : saturating one-step update helpers
package chroma_pkg;

    localparam int unsigned TON_W   = 8;
    localparam int unsigned COLOR_W = 3;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned IN_W    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_REPEAT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_TON  = 2'd1,
        TGT_CL   = 2'd2,
        TGT_CP   = 2'd3
    } tgt_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    localparam logic [TON_W-1:0]   TON_INIT_DEF   = 8'hA4;
    localparam logic [TON_W-1:0]   TON_MAX        = 8'hFF;
    localparam logic [COLOR_W-1:0] COLOR_INIT_DEF = 3'b111;
    localparam logic [COLOR_W-1:0] COLOR_MAX      = 3'b111;

    // Saturating +/-1 on the tone threshold.
    function automatic logic [TON_W-1:0] ton_step(input logic [TON_W-1:0] v, input dir_t d);
        ton_step = v;
        if (d == DIR_UP && v != TON_MAX)
            ton_step = v + TON_W'(1);
        else if (d == DIR_DN && v != '0)
            ton_step = v - TON_W'(1);
    endfunction

    // Saturating +/-1 on a colour register.
    function automatic logic [COLOR_W-1:0] color_step(input logic [COLOR_W-1:0] v, input dir_t d);
        color_step = v;
        if (d == DIR_UP && v != COLOR_MAX)
            color_step = v + COLOR_W'(1);
        else if (d == DIR_DN && v != '0)
            color_step = v - COLOR_W'(1);
    endfunction

endpackage

// File: rtl/chroma_adjust_seq_sync2.sv
// Two-flop synchroniser, parameterised width.
//   clk, reset (sync, active-low) ; d : asynchronous inputs ; q : synchronised outputs
module sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/chroma_adjust_seq.sv
// Chroma-key settings sequencer: synchronises buttons/switches, applies one
// saturating step per press to ton/ColorL/ColorP and auto-repeats while held.
//   clk, reset (sync, active-low)
//   Tono, color, LP : asynchronous mode switches selecting the target
//   UP, down        : asynchronous increment/decrement buttons
//   ton, ColorL, ColorP : settings registers
//   step : one-cycle pulse when a step is applied (even if saturated)
//   busy : high while the sequencer is not idle
module chroma_adjust_seq
    import chroma_pkg::*;
#(
    parameter logic [CNT_W-1:0]   REPEAT_DELAY = 24'd5_000_000,
    parameter logic [CNT_W-1:0]   REPEAT_RATE  = 24'd1_000_000,
    parameter logic [TON_W-1:0]   TON_INIT     = TON_INIT_DEF,
    parameter logic [COLOR_W-1:0] COLOR_INIT   = COLOR_INIT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Tono,
    input  logic               color,
    input  logic               LP,
    input  logic               UP,
    input  logic               down,
    output logic [TON_W-1:0]   ton,
    output logic [COLOR_W-1:0] ColorL,
    output logic [COLOR_W-1:0] ColorP,
    output logic               step,
    output logic               busy
);

    localparam int unsigned B_TONO  = 4;
    localparam int unsigned B_COLOR = 3;
    localparam int unsigned B_LP    = 2;
    localparam int unsigned B_UP    = 1;
    localparam int unsigned B_DOWN  = 0;

    logic [IN_W-1:0]  sync_q;
    dir_t             dir_s;
    tgt_t             tgt_s;
    state_t           state;
    dir_t             dir_l;
    tgt_t             tgt_l;
    logic [CNT_W-1:0] cnt;
    logic             held_c;
    logic             do_step_c;

    sync2 #(.W(IN_W)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({Tono, color, LP, UP, down}),
        .q     (sync_q)
    );

    // Button and mode-switch decode; conflicting buttons mean no direction.
    always_comb begin
        dir_s = DIR_NONE;
        tgt_s = TGT_NONE;
        if (sync_q[B_UP] && !sync_q[B_DOWN])
            dir_s = DIR_UP;
        else if (sync_q[B_DOWN] && !sync_q[B_UP])
            dir_s = DIR_DN;
        if (sync_q[B_TONO])
            tgt_s = TGT_TON;
        else if (sync_q[B_COLOR] && sync_q[B_LP])
            tgt_s = TGT_CL;
        else if (sync_q[B_COLOR])
            tgt_s = TGT_CP;
    end

    // A step fires on FIRST, or on counter expiry while the same button is still held.
    always_comb begin
        held_c    = (dir_s == dir_l);
        do_step_c = 1'b0;
        if (state == ST_FIRST)
            do_step_c = 1'b1;
        else if ((state == ST_WAIT || state == ST_REPEAT) && held_c && cnt == '0)
            do_step_c = 1'b1;
    end

    // Sequencer FSM with hold/repeat counter; target and direction frozen once armed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            dir_l <= DIR_NONE;
            tgt_l <= TGT_NONE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dir_s != DIR_NONE && tgt_s != TGT_NONE) begin
                        dir_l <= dir_s;
                        tgt_l <= tgt_s;
                        state <= ST_FIRST;
                        busy  <= 1'b1;
                    end
                end
                ST_FIRST: begin
                    cnt   <= REPEAT_DELAY - CNT_W'(1);
                    state <= ST_WAIT;
                end
                ST_WAIT, ST_REPEAT: begin
                    if (!held_c) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        cnt   <= REPEAT_RATE - CNT_W'(1);
                        state <= ST_REPEAT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Settings registers; only the latched target moves on a step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ton    <= TON_INIT;
            ColorL <= COLOR_INIT;
            ColorP <= COLOR_INIT;
            step   <= 1'b0;
        end else begin
            step <= do_step_c;
            if (do_step_c) begin
                case (tgt_l)
                    TGT_TON: ton    <= ton_step(ton, dir_l);
                    TGT_CL:  ColorL <= color_step(ColorL, dir_l);
                    TGT_CP:  ColorP <= color_step(ColorP, dir_l);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chroma_adjust_seq.sv
// Self-checking bench for chroma_adjust_seq (REPEAT_DELAY=4, REPEAT_RATE=2).
module tb_chroma_adjust_seq;

    localparam int D = 4;
    localparam int R = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       Tono = 1'b0, color = 1'b0, LP = 1'b0, UP = 1'b0, down = 1'b0;
    logic [7:0] ton;
    logic [2:0] ColorL, ColorP;
    logic       step, busy;

    chroma_adjust_seq #(
        .REPEAT_DELAY (24'd4),
        .REPEAT_RATE  (24'd2),
        .TON_INIT     (8'hA4),
        .COLOR_INIT   (3'b111)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Tono   (Tono),
        .color  (color),
        .LP     (LP),
        .UP     (UP),
        .down   (down),
        .ton    (ton),
        .ColorL (ColorL),
        .ColorP (ColorP),
        .step   (step),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: inputs become visible two edges after sampling; a press
    // arms at detection, steps one edge later, then after D edges, then every R.
    int         m_ton = 8'hA4, m_cl = 7, m_cp = 7;
    bit         m_step = 0, m_active = 0;
    int         m_age = 0, m_ldir = 0, m_ltgt = 0;
    logic [4:0] h1 = '0, h2 = '0;

    function automatic int dec_dir(input logic [4:0] v);
        if (v[1] && !v[0]) return 1;
        if (v[0] && !v[1]) return -1;
        return 0;
    endfunction

    function automatic int dec_tgt(input logic [4:0] v);
        if (v[4]) return 1;
        if (v[3] && v[2]) return 2;
        if (v[3]) return 3;
        return 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_step();
        m_step = 1;
        case (m_ltgt)
            1: m_ton = (m_ldir > 0) ? ((m_ton < 255) ? m_ton + 1 : m_ton) : ((m_ton > 0) ? m_ton - 1 : m_ton);
            2: m_cl  = (m_ldir > 0) ? ((m_cl < 7) ? m_cl + 1 : m_cl) : ((m_cl > 0) ? m_cl - 1 : m_cl);
            3: m_cp  = (m_ldir > 0) ? ((m_cp < 7) ? m_cp + 1 : m_cp) : ((m_cp > 0) ? m_cp - 1 : m_cp);
            default: ;
        endcase
    endtask

    task automatic model_edge();
        int ds, ts, k;
        if (!reset) begin
            m_ton = 8'hA4; m_cl = 7; m_cp = 7;
            m_step = 0; m_active = 0; m_age = 0;
            h1 = '0; h2 = '0;
        end else begin
            ds = dec_dir(h2);
            ts = dec_tgt(h2);
            m_step = 0;
            if (!m_active) begin
                if (ds != 0 && ts != 0) begin
                    m_active = 1; m_age = 0; m_ldir = ds; m_ltgt = ts;
                end
            end else begin
                m_age++;
                k = m_age - 1;
                if (k > 0 && ds != m_ldir)
                    m_active = 0;
                else if (k == 0 || (k >= D && ((k - D) % R) == 0))
                    apply_step();
            end
            h2 = h1;
            h1 = {Tono, color, LP, UP, down};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("ton", 32'(ton), 32'(m_ton));
        check("ColorL", 32'(ColorL), 32'(m_cl));
        check("ColorP", 32'(ColorP), 32'(m_cp));
        check("step", 32'(step), 32'(m_step));
        check("busy", 32'(busy), 32'(m_active));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Runs n cycles, counting DUT step pulses and noting the cycle of the first.
    task automatic run_count(input int n, output int cnt, output int first);
        cnt = 0; first = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (step === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        int cnt, first, seg, len;

        // 1. Reset
        ticks(2);
        check("rst_ton", 32'(ton), 32'h0A4);
        check("rst_cl", 32'(ColorL), 32'd7);
        check("rst_cp", 32'(ColorP), 32'd7);
        check("rst_step", 32'(step), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        ticks(2);

        // 2. Single short press on tone
        Tono = 1'b1; UP = 1'b1;
        run_count(3, cnt, first);
        UP = 1'b0;
        begin
            int c2, f2;
            run_count(8, c2, f2);
            cnt += c2;
            if (first == 0 && f2 != 0) first = f2 + 3;
        end
        check("t2_steps", 32'(cnt), 32'd1);
        check("t2_latency", 32'(first), 32'd4);
        check("t2_ton", 32'(ton), 32'h0A5);
        check("t2_busy", 32'(busy), 32'd0);

        // 3. Held decrement on background colour, saturating at 0
        Tono = 1'b0; color = 1'b1; LP = 1'b0; down = 1'b1;
        run_count(20, cnt, first);
        down = 1'b0;
        begin
            int c2, f2;
            run_count(6, c2, f2);
            cnt += c2;
        end
        check("t3_steps", 32'(cnt), 32'd9);
        check("t3_first", 32'(first), 32'd4);
        check("t3_cp", 32'(ColorP), 32'd0);
        check("t3_cl", 32'(ColorL), 32'd7);

        // 4. Tone saturating at FF
        color = 1'b0; Tono = 1'b1; UP = 1'b1;
        for (int i = 0; i < 400 && m_ton < 8'hFD; i++) tick();
        UP = 1'b0;
        ticks(6);
        check("t4_reach", 32'(ton >= 8'hFD), 32'd1);
        UP = 1'b1;
        ticks(12);
        UP = 1'b0;
        ticks(6);
        check("t4_ton_sat", 32'(ton), 32'h0FF);

        // 5. Both buttons: no action; then target frozen across a mode change
        UP = 1'b1; down = 1'b1;
        run_count(10, cnt, first);
        check("t5_both_steps", 32'(cnt), 32'd0);
        check("t5_both_busy", 32'(busy), 32'd0);
        UP = 1'b0; Tono = 1'b0; color = 1'b1; LP = 1'b1; down = 1'b1;
        ticks(6);
        Tono = 1'b1;
        ticks(8);
        down = 1'b0; Tono = 1'b0;
        ticks(6);
        check("t5_cl", 32'(ColorL), 32'd1);
        check("t5_ton", 32'(ton), 32'h0FF);
        check("t5_cp", 32'(ColorP), 32'd0);

        // 6. Reset during repeat, then fresh press sequence
        LP = 1'b0; UP = 1'b1;
        ticks(12);
        reset = 1'b0;
        tick();
        check("t6_ton", 32'(ton), 32'h0A4);
        check("t6_cl", 32'(ColorL), 32'd7);
        check("t6_cp", 32'(ColorP), 32'd7);
        check("t6_step", 32'(step), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        run_count(5, cnt, first);
        check("t6_restart", 32'(first), 32'd4);
        UP = 1'b0;
        ticks(6);

        // Randomised segments against the model
        seg = 0;
        while (seg < 600) begin
            len = $urandom_range(1, 12);
            Tono  = 1'($urandom_range(0, 3) == 0);
            color = 1'($urandom_range(0, 1));
            LP    = 1'($urandom_range(0, 1));
            UP    = 1'($urandom_range(0, 1));
            down  = 1'($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            ticks(len);
            seg += len + 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
